// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing shared by the display-path blocks.
package vga_timing_pkg;

   localparam int unsigned VGA_WIDTH    = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_PW     = 96;
   localparam int unsigned VGA_H_BP     = 48;
   localparam int unsigned VGA_HEIGHT   = 480;
   localparam int unsigned VGA_V_FP     = 10;
   localparam int unsigned VGA_V_PW     = 2;
   localparam int unsigned VGA_V_BP     = 33;
   localparam int unsigned VGA_CLK_DIV  = 4;
   localparam bit          VGA_SYNC_POL = 1'b0;

   function automatic logic sync_level(input logic asserted, input logic pol);
      return asserted ? pol : ~pol;
   endfunction

endpackage

// File: rtl/vga_sync_axis.sv
// One raster axis: wrap counter with registered sync and look-ahead active decode.
module vga_sync_axis
   import vga_timing_pkg::*;
#(
   parameter int unsigned ACTIVE   = VGA_WIDTH,
   parameter int unsigned FP       = VGA_H_FP,
   parameter int unsigned PW       = VGA_H_PW,
   parameter int unsigned BP       = VGA_H_BP,
   parameter bit          SYNC_POL = VGA_SYNC_POL,
   localparam int unsigned TOT     = ACTIVE + FP + PW + BP,
   localparam int unsigned CW      = $clog2(TOT)
) (
   input  logic          iClk,
   input  logic          iRstN,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic [CW-1:0] count_next,
   output logic          at_end,
   output logic          active_next,
   output logic          sync
);

   localparam logic [CW-1:0] LAST       = CW'(TOT - 1);
   localparam logic [CW-1:0] ACT_LIM    = CW'(ACTIVE);
   localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
   localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + PW - 1);

   logic sync_next;

   always_comb begin
      at_end = (count == LAST);
      if (!en) begin
         count_next = count;
      end else if (at_end) begin
         count_next = '0;
      end else begin
         count_next = count + 1'b1;
      end
      active_next = (count_next < ACT_LIM);
      sync_next   = sync_level((count_next >= SYNC_START) && (count_next <= SYNC_END),
                               SYNC_POL);
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         count <= '0;
         sync  <= ~SYNC_POL;
      end else if (en) begin
         count <= count_next;
         sync  <= sync_next;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel enable, H/V counters, active flag, syncs and frame pulse.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned WIDTH    = VGA_WIDTH,
   parameter int unsigned H_FP     = VGA_H_FP,
   parameter int unsigned H_PW     = VGA_H_PW,
   parameter int unsigned H_BP     = VGA_H_BP,
   parameter int unsigned HEIGHT   = VGA_HEIGHT,
   parameter int unsigned V_FP     = VGA_V_FP,
   parameter int unsigned V_PW     = VGA_V_PW,
   parameter int unsigned V_BP     = VGA_V_BP,
   parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
   parameter bit          SYNC_POL = VGA_SYNC_POL,
   localparam int unsigned H_TOT   = WIDTH + H_FP + H_PW + H_BP,
   localparam int unsigned V_TOT   = HEIGHT + V_FP + V_PW + V_BP,
   localparam int unsigned HW      = $clog2(H_TOT),
   localparam int unsigned VW      = $clog2(V_TOT)
) (
   input  logic          iClk,
   input  logic          iRstN,
   output logic          oPixelTick,
   output logic [HW-1:0] oCountH,
   output logic [VW-1:0] oCountV,
   output logic          oActive,
   output logic          oHSync,
   output logic          oVSync,
   output logic          oFrameTick
);

   localparam int unsigned   DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
   localparam logic [VW-1:0] BLANK_LINE = VW'(HEIGHT);

   logic [DW-1:0] div_q;
   logic          tick_q;
   logic          active_q;
   logic          frame_q;

   logic [HW-1:0] h_next;
   logic [VW-1:0] v_next;
   logic          h_at_end, v_at_end;
   logic          h_act_next, v_act_next;
   logic          v_en;

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         tick_q <= (div_q == DIV_LAST);
         div_q  <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      end
   end

   assign v_en = tick_q & h_at_end;

   vga_sync_axis #(
      .ACTIVE   (WIDTH),
      .FP       (H_FP),
      .PW       (H_PW),
      .BP       (H_BP),
      .SYNC_POL (SYNC_POL)
   ) u_h_axis (
      .iClk        (iClk),
      .iRstN       (iRstN),
      .en          (tick_q),
      .count       (oCountH),
      .count_next  (h_next),
      .at_end      (h_at_end),
      .active_next (h_act_next),
      .sync        (oHSync)
   );

   vga_sync_axis #(
      .ACTIVE   (HEIGHT),
      .FP       (V_FP),
      .PW       (V_PW),
      .BP       (V_BP),
      .SYNC_POL (SYNC_POL)
   ) u_v_axis (
      .iClk        (iClk),
      .iRstN       (iRstN),
      .en          (v_en),
      .count       (oCountV),
      .count_next  (v_next),
      .at_end      (v_at_end),
      .active_next (v_act_next),
      .sync        (oVSync)
   );

   // Active only reloads with the counters, so pixel (0,0) after reset stays blanked.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         active_q <= 1'b0;
         frame_q  <= 1'b0;
      end else begin
         frame_q <= v_en & (v_next == BLANK_LINE);
         if (tick_q) begin
            active_q <= h_act_next & v_act_next;
         end
      end
   end

   assign oPixelTick = tick_q;
   assign oActive    = active_q;
   assign oFrameTick = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three configurations checked every clock against an arithmetic raster model.
module tb_vga_timing_gen;

   typedef struct {
      logic tick;
      int   h;
      int   v;
      logic act;
      logic hs;
      logic vs;
      logic ft;
   } exp_t;

   typedef struct {
      int w, hfp, hpw, hbp, hgt, vfp, vpw, vbp, div;
      bit pol;
   } cfg_t;

   // Config A: tiny raster, CLK_DIV=1, active-low syncs
   localparam int A_W = 8, A_HFP = 1, A_HPW = 2, A_HBP = 1;
   localparam int A_H = 4, A_VFP = 1, A_VPW = 1, A_VBP = 1;
   localparam int A_D = 1;
   localparam bit A_P = 1'b0;
   // Config B: odd divider, active-high syncs
   localparam int B_W = 10, B_HFP = 2, B_HPW = 3, B_HBP = 2;
   localparam int B_H = 5, B_VFP = 1, B_VPW = 2, B_VBP = 1;
   localparam int B_D = 3;
   localparam bit B_P = 1'b1;
   // Config C: default 640x480 timing, first lines only
   localparam int C_W = 640, C_HFP = 16, C_HPW = 96, C_HBP = 48;
   localparam int C_H = 480, C_VFP = 10, C_VPW = 2, C_VBP = 33;
   localparam int C_D = 4;
   localparam bit C_P = 1'b0;

   localparam int AHW = $clog2(A_W + A_HFP + A_HPW + A_HBP);
   localparam int AVW = $clog2(A_H + A_VFP + A_VPW + A_VBP);
   localparam int BHW = $clog2(B_W + B_HFP + B_HPW + B_HBP);
   localparam int BVW = $clog2(B_H + B_VFP + B_VPW + B_VBP);
   localparam int CHW = $clog2(C_W + C_HFP + C_HPW + C_HBP);
   localparam int CVW = $clog2(C_H + C_VFP + C_VPW + C_VBP);

   localparam int NSEG = 12;

   logic clk;
   logic rst_n;

   logic           a_tick, a_act, a_hs, a_vs, a_ft;
   logic [AHW-1:0] a_h;
   logic [AVW-1:0] a_v;
   logic           b_tick, b_act, b_hs, b_vs, b_ft;
   logic [BHW-1:0] b_h;
   logic [BVW-1:0] b_v;
   logic           c_tick, c_act, c_hs, c_vs, c_ft;
   logic [CHW-1:0] c_h;
   logic [CVW-1:0] c_v;

   vga_timing_gen #(
      .WIDTH(A_W), .H_FP(A_HFP), .H_PW(A_HPW), .H_BP(A_HBP),
      .HEIGHT(A_H), .V_FP(A_VFP), .V_PW(A_VPW), .V_BP(A_VBP),
      .CLK_DIV(A_D), .SYNC_POL(A_P)
   ) dut_a (
      .iClk(clk), .iRstN(rst_n), .oPixelTick(a_tick), .oCountH(a_h), .oCountV(a_v),
      .oActive(a_act), .oHSync(a_hs), .oVSync(a_vs), .oFrameTick(a_ft)
   );

   vga_timing_gen #(
      .WIDTH(B_W), .H_FP(B_HFP), .H_PW(B_HPW), .H_BP(B_HBP),
      .HEIGHT(B_H), .V_FP(B_VFP), .V_PW(B_VPW), .V_BP(B_VBP),
      .CLK_DIV(B_D), .SYNC_POL(B_P)
   ) dut_b (
      .iClk(clk), .iRstN(rst_n), .oPixelTick(b_tick), .oCountH(b_h), .oCountV(b_v),
      .oActive(b_act), .oHSync(b_hs), .oVSync(b_vs), .oFrameTick(b_ft)
   );

   vga_timing_gen #(
      .WIDTH(C_W), .H_FP(C_HFP), .H_PW(C_HPW), .H_BP(C_HBP),
      .HEIGHT(C_H), .V_FP(C_VFP), .V_PW(C_VPW), .V_BP(C_VBP),
      .CLK_DIV(C_D), .SYNC_POL(C_P)
   ) dut_c (
      .iClk(clk), .iRstN(rst_n), .oPixelTick(c_tick), .oCountH(c_h), .oCountV(c_v),
      .oActive(c_act), .oHSync(c_hs), .oVSync(c_vs), .oFrameTick(c_ft)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   cfg_t cfg [3];
   exp_t qa [$];
   exp_t qb [$];
   exp_t qc [$];
   int   n_tests = 0;
   int   n_fail  = 0;
   event chk_ev;

   // Expected outputs k clocks after reset release (k=0: still in reset).
   // Pixel ticks land on clocks D,2D,...; the counters advance one clock later.
   function automatic exp_t model(input cfg_t c, input int k);
      exp_t e;
      int   ht, vt, a, p, hh, vv;
      bit   adv;
      ht = c.w + c.hfp + c.hpw + c.hbp;
      vt = c.hgt + c.vfp + c.vpw + c.vbp;
      a  = (k >= 1) ? (k - 1) / c.div : 0;
      p  = a % (ht * vt);
      hh = p % ht;
      vv = p / ht;
      adv = (k >= 2) && ((k - 1) % c.div == 0);
      e.tick = (k >= 1) && (k % c.div == 0);
      e.h    = hh;
      e.v    = vv;
      e.act  = (a >= 1) && (hh < c.w) && (vv < c.hgt);
      e.hs   = ((hh >= c.w + c.hfp) && (hh < c.w + c.hfp + c.hpw)) ? c.pol : !c.pol;
      e.vs   = ((vv >= c.hgt + c.vfp) && (vv < c.hgt + c.vfp + c.vpw)) ? c.pol : !c.pol;
      e.ft   = adv && (hh == 0) && (vv == c.hgt);
      return e;
   endfunction

   task automatic push_all(input int k);
      qa.push_back(model(cfg[0], k));
      qb.push_back(model(cfg[1], k));
      qc.push_back(model(cfg[2], k));
   endtask

   task automatic compare(input string name, input exp_t e, input exp_t g);
      n_tests++;
      if (g.tick !== e.tick || g.h != e.h || g.v != e.v || g.act !== e.act ||
          g.hs !== e.hs || g.vs !== e.vs || g.ft !== e.ft) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s t=%0t got tick=%0b h=%0d v=%0d act=%0b hs=%0b vs=%0b ft=%0b required tick=%0b h=%0d v=%0d act=%0b hs=%0b vs=%0b ft=%0b",
                     name, $time, g.tick, g.h, g.v, g.act, g.hs, g.vs, g.ft,
                     e.tick, e.h, e.v, e.act, e.hs, e.vs, e.ft);
      end
   endtask

   // Monitor: samples after every falling edge, and right after an asynchronous reset.
   initial begin
      exp_t g;
      forever begin
         @(negedge clk or chk_ev);
         #1;
         if (qa.size() != 0) begin
            g.tick = a_tick; g.h = int'(a_h); g.v = int'(a_v); g.act = a_act;
            g.hs = a_hs; g.vs = a_vs; g.ft = a_ft;
            compare("cfg_a", qa.pop_front(), g);
         end
         if (qb.size() != 0) begin
            g.tick = b_tick; g.h = int'(b_h); g.v = int'(b_v); g.act = b_act;
            g.hs = b_hs; g.vs = b_vs; g.ft = b_ft;
            compare("cfg_b", qb.pop_front(), g);
         end
         if (qc.size() != 0) begin
            g.tick = c_tick; g.h = int'(c_h); g.v = int'(c_v); g.act = c_act;
            g.hs = c_hs; g.vs = c_vs; g.ft = c_ft;
            compare("cfg_c", qc.pop_front(), g);
         end
      end
   end

   // Driver: random run lengths, each ended by an asynchronous mid-cycle reset.
   initial begin
      int k;
      int len;
      cfg[0] = '{A_W, A_HFP, A_HPW, A_HBP, A_H, A_VFP, A_VPW, A_VBP, A_D, A_P};
      cfg[1] = '{B_W, B_HFP, B_HPW, B_HBP, B_H, B_VFP, B_VPW, B_VBP, B_D, B_P};
      cfg[2] = '{C_W, C_HFP, C_HPW, C_HBP, C_H, C_VFP, C_VPW, C_VBP, C_D, C_P};
      rst_n = 1'b0;
      k = 0;
      repeat (3) begin
         @(posedge clk);
         push_all(0);
      end
      for (int seg = 0; seg < NSEG; seg++) begin
         @(negedge clk);
         #2 rst_n = 1'b1;
         k = 0;
         // First run crosses the default-timing line wrap; second stops inside its HSync.
         if (seg == 0)      len = 3300;
         else if (seg == 1) len = 2805;
         else               len = int'($urandom_range(40, 1200));
         repeat (len) begin
            @(posedge clk);
            k++;
            push_all(k);
         end
         @(negedge clk);
         #2 rst_n = 1'b0;
         push_all(0);
         ->chk_ev;
         repeat (int'($urandom_range(1, 3))) begin
            @(posedge clk);
            push_all(0);
         end
      end
      @(negedge clk);
      #3;
      n_tests++;
      if (qa.size() + qb.size() + qc.size() != 0) begin
         n_fail++;
         $display("FAIL drain got %0d pending entries required 0",
                  qa.size() + qb.size() + qc.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
